// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty for even and odd ratios.
// Ratio changes, starts and stops all take effect at period boundaries.
module clk_div_prog #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DIV_RST = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_busy,
    output logic [CNT_W-1:0] div_cur,
    output logic             clk_out,
    output logic             clk_rise,
    output logic             clk_fall
);

    localparam logic [CNT_W-1:0] DivRstC = (DIV_RST < 2) ? CNT_W'(2) : CNT_W'(DIV_RST);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_p_q, clk_p_d;
    logic             clk_n_q;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt_inc;
    logic             start;
    logic             wrap;
    logic             xfer;

    assign half    = div_cur_q >> 1;
    assign cnt_inc = cnt_q + CNT_W'(1);
    // The first RUN cycle is the only one with cnt==0 and clk_p low; treat it as a boundary.
    assign start   = (cnt_q == '0) && !clk_p_q;
    assign wrap    = (state_q == StRun) && (start || (cnt_q == div_cur_q - CNT_W'(1)));
    assign xfer    = (state_q == StIdle) || wrap;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clk_p_d = clk_p_q;
        unique case (state_q)
            StIdle: begin
                cnt_d   = '0;
                clk_p_d = 1'b0;
                if (enable) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (wrap) begin
                    cnt_d = '0;
                    if (enable) begin
                        clk_p_d = 1'b1;
                    end else begin
                        clk_p_d = 1'b0;
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == half) begin
                        clk_p_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // A load on the transfer edge stays pending: the old pending value moves first.
    always_comb begin
        pend_d    = pend_q;
        busy_d    = busy_q;
        div_cur_d = div_cur_q;
        if (busy_q && xfer) begin
            div_cur_d = pend_q;
            busy_d    = 1'b0;
        end
        if (div_load) begin
            pend_d = (div_val < CNT_W'(2)) ? CNT_W'(2) : div_val;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            clk_p_q   <= 1'b0;
            div_cur_q <= DivRstC;
            pend_q    <= DivRstC;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clk_p_q   <= clk_p_d;
            div_cur_q <= div_cur_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
        end
    end

    // Half-cycle delayed copy stretches the high phase by 0.5 cycle for odd ratios.
    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            clk_n_q <= 1'b0;
        end else begin
            clk_n_q <= clk_p_q;
        end
    end

    assign clk_out  = div_cur_q[0] ? (clk_p_q | clk_n_q) : clk_p_q;
    assign clk_rise = (state_q == StRun) && (cnt_q == '0) && clk_p_q;
    assign clk_fall = (state_q == StRun) && (cnt_q == half);
    assign div_busy = busy_q;
    assign div_cur  = div_cur_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: expected ratio/phase lengths are queued at each
// load or start and compared against measured clk_out periods in half-cycle units.
module tb_clk_div_prog;

    localparam int unsigned CNT_W = 8;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             div_busy;
    logic [CNT_W-1:0] div_cur;
    logic             clk_out;
    logic             clk_rise;
    logic             clk_fall;

    clk_div_prog #(
        .CNT_W  (CNT_W),
        .DIV_RST(2)
    ) u_dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .enable  (enable),
        .div_val (div_val),
        .div_load(div_load),
        .div_busy(div_busy),
        .div_cur (div_cur),
        .clk_out (clk_out),
        .clk_rise(clk_rise),
        .clk_fall(clk_fall)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int n;
        int hi;
        int lo;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   pend_open = 1'b0;
    bit   mon_en    = 1'b0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Phase lengths in half cycles: N/2 clk_in cycles each way for any N.
    function automatic exp_t mk_exp(input int v);
        exp_t e;
        e.n  = (v < 2) ? 2 : v;
        e.hi = e.n;
        e.lo = e.n;
        return e;
    endfunction

    task automatic measure(input int n, output int hi, output int lo);
        int   h;
        int   idx;
        int   steps;
        logic prev;
        h     = n / 2;
        hi    = 0;
        lo    = 0;
        steps = 0;
        prev  = clk_out;
        forever begin
            @(clk_in);
            #1;
            steps++;
            if (!prev && clk_out) break;
            prev = clk_out;
            if (steps > 400) begin
                check_eq("rise_timeout", 0, 1);
                return;
            end
        end
        check_eq("clk_rise", int'(clk_rise), 1);
        idx = 0;
        hi  = 1;
        forever begin
            @(clk_in);
            #1;
            idx++;
            if (clk_in && idx == 2 * h) check_eq("clk_fall", int'(clk_fall), 1);
            if (!clk_out) break;
            hi++;
            if (idx > 600) begin
                check_eq("high_timeout", 0, 1);
                return;
            end
        end
        lo = 1;
        forever begin
            @(clk_in);
            #1;
            idx++;
            if (clk_in && idx == 2 * h) check_eq("clk_fall", int'(clk_fall), 1);
            if (clk_out) break;
            lo++;
            if (idx > 1200) begin
                check_eq("low_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic check_period();
        exp_t e;
        int   hi;
        int   lo;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check_eq("div_cur", int'(div_cur), e.n);
        measure(e.n, hi, lo);
        check_eq("high_halves", hi, e.hi);
        check_eq("low_halves", lo, e.lo);
    endtask

    task automatic load(input int v);
        @(posedge clk_in);
        #2;
        div_val  = CNT_W'(v);
        div_load = 1'b1;
        @(posedge clk_in);
        #2;
        div_load = 1'b0;
        check_eq("busy_set", int'(div_busy), 1);
        // Last load wins while a transfer is still outstanding.
        if (pend_open) sb[sb.size()-1] = mk_exp(v);
        else sb.push_back(mk_exp(v));
        pend_open = 1'b1;
    endtask

    task automatic wait_xfer();
        int k;
        for (k = 0; k < 200; k++) begin
            if (!div_busy) break;
            @(posedge clk_in);
            #2;
        end
        if (k == 200) check_eq("busy_timeout", 0, 1);
        pend_open = 1'b0;
        check_period();
    endtask

    // Any clk_out phase shorter than one clk_in cycle is a runt.
    initial begin
        logic mon_prev;
        int   run_len;
        mon_prev = 1'b0;
        run_len  = 0;
        forever begin
            @(clk_in);
            #1;
            if (!mon_en) begin
                run_len = 0;
            end else if (clk_out != mon_prev) begin
                if (run_len > 0) check_eq("min_phase", int'(run_len >= 2), 1);
                run_len = 1;
            end else if (run_len > 0) begin
                run_len++;
            end
            mon_prev = clk_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n    = 1'b0;
        enable   = 1'b0;
        div_load = 1'b0;
        div_val  = '0;
        repeat (3) @(posedge clk_in);
        #2;
        check_eq("rst_clk_out", int'(clk_out), 0);
        check_eq("rst_div_cur", int'(div_cur), 2);
        check_eq("rst_busy", int'(div_busy), 0);
        check_eq("rst_rise", int'(clk_rise), 0);
        check_eq("rst_fall", int'(clk_fall), 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        mon_en = 1'b1;
        sb.push_back(mk_exp(2));
        check_period();

        load(6);
        wait_xfer();
        load(5);
        wait_xfer();
        load(0);
        wait_xfer();
        load(7);
        wait_xfer();

        // Two loads inside one N=7 period: only the second may be applied.
        k = 0;
        while (!clk_rise && k < 50) begin
            @(posedge clk_in);
            #1;
            k++;
        end
        load(3);
        load(9);
        check_eq("busy_hold_cur", int'(div_cur), 7);
        wait_xfer();

        load(1);
        wait_xfer();
        load(8);
        wait_xfer();

        // check_period leaves us just after a rise (cnt==0); drop enable at cnt==2.
        @(posedge clk_in);
        @(posedge clk_in);
        #2;
        enable = 1'b0;
        k = 1;
        forever begin
            @(posedge clk_in);
            #1;
            if (!clk_out || k > 20) break;
            k++;
        end
        check_eq("stop_high_tail", k, 2);
        k = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk_in);
            #1;
            if (clk_out || clk_rise) k++;
        end
        check_eq("stopped_quiet", k, 0);

        @(posedge clk_in);
        #2;
        enable = 1'b1;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk_in);
            #1;
            if (clk_rise) begin
                k = i;
                break;
            end
        end
        check_eq("restart_latency", k, 2);
        sb.push_back(mk_exp(8));
        check_period();

        // A pending ratio must be discarded by a mid-high-phase reset.
        load(5);
        k = 0;
        while (!(clk_in && clk_out) && k < 100) begin
            @(clk_in);
            #1;
            k++;
        end
        mon_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_clk_out", int'(clk_out), 0);
        check_eq("arst_div_cur", int'(div_cur), 2);
        check_eq("arst_busy", int'(div_busy), 0);
        check_eq("arst_rise", int'(clk_rise), 0);
        sb.delete();
        pend_open = 1'b0;
        repeat (2) @(posedge clk_in);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        sb.push_back(mk_exp(2));
        check_period();
        @(posedge clk_in);
        check_eq("post_rst_busy", int'(div_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
